mips_mem_responder: RTL
=======================

Name: mips_mem_responder

Overview:
- Memory-side responder for the MIPS32 core: serves instruction fetches (I-port, read-only) and LW/SW data accesses (D-port) from one shared 32-bit word-addressed memory array.
- Uses a req/ack handshake with a configurable number of wait states.
- Arbitrates the two ports so neither starves.
- Replaces the core's internal Mem array once the pipeline moves to stall-on-ack memory.

Parameters:
DEPTH, 1024, number of 32-bit words in the array
AW, 10, address bits used for indexing (log2 DEPTH)
WAIT_CYCLES, 2, wait states between acceptance and ack (0..15)

Ports:
clk1  input  1  clock (phase-1 clock of the core's clock scheme); all state changes on posedge
reset  input  1  asynchronous, active-high reset
i_req  input  1  instruction fetch request; held high until i_ack
i_addr  input  32  fetch word address
i_rdata  output  32  fetched instruction; valid only while i_ack=1
i_ack  output  1  one-cycle completion pulse for the I-port
d_req  input  1  data request; held high until d_ack
d_we  input  1  1 = store (SW), 0 = load (LW)
d_addr  input  32  data word address
d_wdata  input  32  store data
d_rdata  output  32  load data; valid only while d_ack=1
d_ack  output  1  one-cycle completion pulse for the D-port
d_err  output  1  asserted with d_ack when d_addr >= DEPTH
i_err  output  1  asserted with i_ack when i_addr >= DEPTH
busy  output  1  high in every state other than IDLE

Behaviour:
- Reset (async assert, sync release):
  - i_ack, d_ack, i_err, d_err, i_rdata, d_rdata all 0; busy = 0.
  - state = IDLE; wait counter = 0; last_grant = I, so D wins the first contention.
  - Memory contents are not reset.
- Reset mid-transaction aborts it: no write, no ack. The initiator must re-request.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Samples both reqs at each posedge.
  - If only one req is high, that port is granted.
  - If both are high, grant the port that was not last_grant (round-robin).
  - On grant, latch port, addr, we and wdata. Load counter = WAIT_CYCLES.
  - Next state: WAIT if WAIT_CYCLES > 0, otherwise RESP.
- WAIT:
  - Decrement the counter each posedge.
  - Go to RESP on the edge where the counter reaches 0.
  - Input changes during WAIT are ignored; the latched copies are used.
- RESP (exactly one cycle):
  - ack for the granted port = 1; the other port's ack stays 0.
  - Read: rdata = Mem[addr[AW-1:0]].
  - Write: Mem updated at the edge entering RESP; rdata = 0.
  - Update last_grant. Next state is IDLE.
- Latency: request accepted at edge k, ack high in the cycle after edge k+1+WAIT_CYCLES. With the default parameter, ack arrives 3 cycles after acceptance.
- Handshake:
  - Ack is a single-cycle pulse; rdata and err are valid only in that cycle and return to 0 afterwards.
  - The initiator drops req, or presents a new request, in the cycle after ack.
  - The IDLE cycle following RESP treats a high req as a new request, so back-to-back is legal with one idle cycle between transactions.
- Out of range (addr >= DEPTH, checked on full 32 bits):
  - The transaction completes normally with ack and err = 1.
  - No write occurs; rdata = 0.
- Arithmetic: addr is an unsigned word address. Upper bits beyond AW are used only for the range check, never wrapped.
- No read-modify-write and no byte enables: stores are full 32-bit words.
- A read of a location written by the immediately preceding D transaction returns the new value.

Test Plan:
- Reset then I-read: preload Mem[5]=32'h2801000A; i_req, i_addr=5 at edge 0 → i_ack=1 with i_rdata=32'h2801000A exactly in the cycle after edge 3 (WAIT_CYCLES=2); busy high for 3 cycles.
- Store then load: d_we=1, d_addr=100, d_wdata=32'hDEADBEEF → d_ack; then d_we=0, d_addr=100 → d_rdata=32'hDEADBEEF; i_ack stays 0 throughout.
- Contention: i_req and d_req both held high continuously from reset → grants alternate D, I, D, I; each port sees an ack every 8 cycles; no port is starved.
- Out of range: d_we=1, d_addr=1024, d_wdata=1 → d_ack=1, d_err=1; Mem[0] unchanged; subsequent load of 1024 → d_rdata=0, d_err=1.
- Reset mid-WAIT: store to addr 7 accepted, reset asserted during WAIT → no d_ack; Mem[7] keeps its old value; all outputs 0 and state IDLE immediately (async).
- WAIT_CYCLES=0 build: i_req at edge 0 → i_ack in the cycle after edge 1; back-to-back fetches of 0,1,2 complete on alternating cycles.

Source files
------------

// File: rtl/mips_mem_if.sv
// Bus between the MIPS32 core (master) and the shared-memory responder (slave).
// Handshake: a port raises req with its address/data and holds them steady until ack. ack is a one-cycle pulse; rdata/err are valid only with it.
`timescale 1ns/1ps
interface mips_mem_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, busy
    );
endinterface

// File: rtl/mips_mem_responder.sv
// Shared word memory serving the I-port (fetch) and D-port (LW/SW) with round-robin
// arbitration, WAIT_CYCLES wait states and a one-cycle registered ack.
`timescale 1ns/1ps
module mips_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk1,
    input  logic        reset,
    mips_mem_if.slave   bus,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        port_q;      // 1 = D-port owns the current transaction
    logic        last_q;      // 1 = D-port was granted last
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        i_ack_q, d_ack_q, i_err_q, d_err_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic [31:0] mem_q [DEPTH];

    logic        grant_any;
    logic        grant_d;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic        mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        resp_err;

    always_comb begin
        grant_any = bus.i_req | bus.d_req;
        grant_d   = bus.d_req & (~bus.i_req | ~last_q);
        sel_addr  = grant_d ? bus.d_addr : bus.i_addr;
        sel_we    = grant_d & bus.d_we;
        resp_err  = (addr_q >= DEPTH_W);
    end

    // The store lands on the edge that enters RESP; with no wait states that is the grant edge itself.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q[AW-1:0];
        mem_wdata = wdata_q;
        if (WAIT_CYCLES == 0) begin
            if (state_q == IDLE && grant_any && sel_we && sel_addr < DEPTH_W) begin
                mem_we    = 1'b1;
                mem_waddr = sel_addr[AW-1:0];
                mem_wdata = bus.d_wdata;
            end
        end else if (state_q == WAIT && cnt_q == 4'd1 && we_q && !resp_err) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            port_q    <= 1'b0;
            last_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        port_q  <= grant_d;
                        addr_q  <= sel_addr;
                        we_q    <= sel_we;
                        wdata_q <= bus.d_wdata;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_q <= RESP;
                end
                RESP: begin
                    last_q  <= port_q;
                    state_q <= IDLE;
                    if (port_q) begin
                        d_ack_q   <= 1'b1;
                        d_err_q   <= resp_err;
                        d_rdata_q <= (!we_q && !resp_err) ? mem_q[addr_q[AW-1:0]] : 32'd0;
                    end else begin
                        i_ack_q   <= 1'b1;
                        i_err_q   <= resp_err;
                        i_rdata_q <= resp_err ? 32'd0 : mem_q[addr_q[AW-1:0]];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.i_err   = i_err_q;
    assign bus.d_err   = d_err_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = (state_q != IDLE);
    assign state_o     = state_q;
endmodule
